// File: rtl/load_store_unit.sv
// load_store_unit: memory-stage load/store unit in front of a word-addressed
// 32-bit data memory. Handles byte/halfword/word accesses, sign/zero
// extension on loads and read-modify-write merging for sub-word stores.
// Rejects misaligned, out-of-range, reserved-size and read+write requests.
module load_store_unit #(
  parameter int MEM_WORDS = 64
) (
  input  logic        Clk_40,
  input  logic        Reset_n_40,
  input  logic        MemRead_in_40,
  input  logic        MemWrite_in_40,
  input  logic [1:0]  Size_40,
  input  logic        Unsigned_40,
  input  logic [31:0] Address_in_40,
  input  logic [31:0] StoreData_40,
  output logic [31:0] LoadData_40,
  output logic        Stall_40,
  output logic        AddrErr_40,
  output logic [31:0] Address_40,
  output logic [31:0] WriteData_40,
  output logic        MemRead_40,
  output logic        MemWrite_40,
  input  logic [31:0] ReadData_40
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] COMMIT = 1'b1;

  localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS * 4);

  logic [0:0]  state_reg, state_next;
  logic [31:0] merge_reg, merge_next;
  logic [31:0] addr_reg, addr_next;

  logic        req, misalign, bad_size, out_of_range, both_set, err;
  logic        valid_load, valid_store, sub_store;
  logic [31:0] word_addr;
  logic [7:0]  byte_lane [4];
  logic [15:0] half_lane [2];
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] load_ext;
  logic [31:0] merged;

  // Request decode and error classification
  always_comb begin
    req          = MemRead_in_40 | MemWrite_in_40;
    misalign     = ((Size_40 == 2'b01) && Address_in_40[0]) ||
                   ((Size_40 == 2'b10) && (Address_in_40[1:0] != 2'b00));
    bad_size     = (Size_40 == 2'b11);
    out_of_range = (Address_in_40 >= MEM_BYTES);
    both_set     = MemRead_in_40 & MemWrite_in_40;
    err          = req & (misalign | bad_size | out_of_range | both_set);
    valid_load   = MemRead_in_40 & ~err;
    valid_store  = MemWrite_in_40 & ~err;
    sub_store    = valid_store & (Size_40 != 2'b10);
    word_addr    = {Address_in_40[31:2], 2'b00};
  end

  // Split the read word into little-endian lanes; build the merged store word
  // by replacing only the lane(s) the sub-word store targets.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_byte
      assign byte_lane[gi] = ReadData_40[8*gi +: 8];
      assign merged[8*gi +: 8] =
        ((Size_40 == 2'b00) && (Address_in_40[1:0] == 2'(gi))) ? StoreData_40[7:0] :
        ((Size_40 == 2'b01) && (Address_in_40[1] == 1'(gi / 2)))
                                                  ? StoreData_40[8*(gi % 2) +: 8] :
                                                    ReadData_40[8*gi +: 8];
    end
    for (gi = 0; gi < 2; gi++) begin : g_half
      assign half_lane[gi] = ReadData_40[16*gi +: 16];
    end
  endgenerate

  // Lane selection and sign/zero extension of the load result
  always_comb begin
    sel_byte = byte_lane[Address_in_40[1:0]];
    sel_half = half_lane[Address_in_40[1]];
    case (Size_40)
      2'b00:   load_ext = Unsigned_40 ? {24'h0, sel_byte} : {{24{sel_byte[7]}}, sel_byte};
      2'b01:   load_ext = Unsigned_40 ? {16'h0, sel_half} : {{16{sel_half[15]}}, sel_half};
      default: load_ext = ReadData_40;
    endcase
  end

  // Output decode; everything is forced low while reset is asserted so a
  // pending COMMIT write is dropped immediately.
  always_comb begin
    LoadData_40  = 32'h0;
    Stall_40     = 1'b0;
    AddrErr_40   = 1'b0;
    Address_40   = 32'h0;
    WriteData_40 = 32'h0;
    MemRead_40   = 1'b0;
    MemWrite_40  = 1'b0;
    if (Reset_n_40) begin
      if (state_reg == COMMIT) begin
        MemWrite_40  = 1'b1;
        WriteData_40 = merge_reg;
        Address_40   = addr_reg;
      end else if (err) begin
        AddrErr_40 = 1'b1;
      end else if (valid_load) begin
        MemRead_40  = 1'b1;
        Address_40  = word_addr;
        LoadData_40 = load_ext;
      end else if (valid_store) begin
        Address_40 = word_addr;
        if (sub_store) begin
          MemRead_40 = 1'b1;
          Stall_40   = 1'b1;
        end else begin
          MemWrite_40  = 1'b1;
          WriteData_40 = StoreData_40;
        end
      end
    end
  end

  // Next-state logic: sub-word store captures merged word, then commits
  always_comb begin
    state_next = state_reg;
    merge_next = merge_reg;
    addr_next  = addr_reg;
    if (state_reg == COMMIT) begin
      state_next = IDLE;
    end else if (sub_store) begin
      state_next = COMMIT;
      merge_next = merged;
      addr_next  = word_addr;
    end
  end

  // State, merge buffer and registered word address
  always_ff @(posedge Clk_40 or negedge Reset_n_40) begin
    if (!Reset_n_40) begin
      state_reg <= IDLE;
      merge_reg <= 32'h0;
      addr_reg  <= 32'h0;
    end else begin
      state_reg <= state_next;
      merge_reg <= merge_next;
      addr_reg  <= addr_next;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: stimulus pushes expected memory
// writes, load results and rejections; a negedge monitor pops and compares.
module tb_load_store_unit;

  localparam logic [1:0] K_WR  = 2'd0;
  localparam logic [1:0] K_LD  = 2'd1;
  localparam logic [1:0] K_ERR = 2'd2;

  typedef struct {
    logic [1:0]  kind;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  logic        Clk_40 = 1'b0;
  logic        Reset_n_40;
  logic        MemRead_in_40, MemWrite_in_40, Unsigned_40;
  logic [1:0]  Size_40;
  logic [31:0] Address_in_40, StoreData_40;
  logic [31:0] LoadData_40, Address_40, WriteData_40, ReadData_40;
  logic        Stall_40, AddrErr_40, MemRead_40, MemWrite_40;

  logic [31:0] mem [64];
  logic        preload;
  exp_t        sb_q [$];
  int          checks = 0;
  int          fails  = 0;

  load_store_unit #(.MEM_WORDS(64)) dut (
    .Clk_40(Clk_40), .Reset_n_40(Reset_n_40),
    .MemRead_in_40(MemRead_in_40), .MemWrite_in_40(MemWrite_in_40),
    .Size_40(Size_40), .Unsigned_40(Unsigned_40),
    .Address_in_40(Address_in_40), .StoreData_40(StoreData_40),
    .LoadData_40(LoadData_40), .Stall_40(Stall_40), .AddrErr_40(AddrErr_40),
    .Address_40(Address_40), .WriteData_40(WriteData_40),
    .MemRead_40(MemRead_40), .MemWrite_40(MemWrite_40),
    .ReadData_40(ReadData_40)
  );

  always #5 Clk_40 = ~Clk_40;

  // Data memory model: combinational read, write on rising edge
  assign ReadData_40 = MemRead_40 ? mem[Address_40[7:2]] : 32'h0;
  always @(posedge Clk_40) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      mem[5] <= 32'h11223344;
      mem[6] <= 32'h55667788;
    end else if (MemWrite_40) begin
      mem[Address_40[7:2]] <= WriteData_40;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: one comparison set per DUT-visible transaction
  always @(negedge Clk_40) begin
    logic [1:0] kind;
    logic       seen;
    exp_t       e;
    seen = 1'b1;
    kind = K_WR;
    if (MemWrite_40)                    kind = K_WR;
    else if (AddrErr_40)                kind = K_ERR;
    else if (MemRead_40 && !Stall_40)   kind = K_LD;
    else                                seen = 1'b0;
    if (Reset_n_40 && seen) begin
      if (sb_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_txn: got kind %0d addr %h with empty queue", kind, Address_40);
      end else begin
        e = sb_q.pop_front();
        check("txn_kind", 32'(kind), 32'(e.kind));
        case (e.kind)
          K_WR: begin
            check("wr_addr", Address_40, e.addr);
            check("wr_data", WriteData_40, e.data);
            $display("txn WRITE addr=%h data=%h", Address_40, WriteData_40);
          end
          K_LD: begin
            check("ld_addr", Address_40, e.addr);
            check("ld_data", LoadData_40, e.data);
            $display("txn LOAD  addr=%h data=%h", Address_40, LoadData_40);
          end
          default: begin
            check("err_ctrl", {29'h0, MemRead_40, MemWrite_40, Stall_40}, 32'h0);
            check("err_ldata", LoadData_40, 32'h0);
            $display("txn ERROR addr_in=%h", Address_in_40);
          end
        endcase
      end
    end
  end

  task automatic push(input logic [1:0] kind, input logic [31:0] addr, input logic [31:0] data);
    exp_t e;
    e.kind = kind; e.addr = addr; e.data = data;
    sb_q.push_back(e);
  endtask

  task automatic idle_inputs();
    MemRead_in_40 = 1'b0; MemWrite_in_40 = 1'b0; Size_40 = 2'b00;
    Unsigned_40 = 1'b0; Address_in_40 = 32'h0; StoreData_40 = 32'h0;
  endtask

  // Present one request, hold it while stalled, and count stall cycles
  task automatic issue(input logic rd, input logic wr, input logic [1:0] size,
                       input logic uns, input logic [31:0] addr,
                       input logic [31:0] data, input int exp_stalls);
    int stalls;
    MemRead_in_40 = rd; MemWrite_in_40 = wr; Size_40 = size;
    Unsigned_40 = uns; Address_in_40 = addr; StoreData_40 = data;
    stalls = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge Clk_40);
      if (!Stall_40) break;
      stalls++;
      @(posedge Clk_40); #1;
    end
    @(posedge Clk_40); #1;
    check("stall_cycles", 32'(stalls), 32'(exp_stalls));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset_n_40 = 1'b0;
    preload = 1'b1;
    idle_inputs();
    MemRead_in_40 = 1'b1; Size_40 = 2'b10; Address_in_40 = 32'h14;
    @(posedge Clk_40); #1;
    check("reset_outputs",
          LoadData_40 | Address_40 | WriteData_40 |
          {28'h0, Stall_40, AddrErr_40, MemRead_40, MemWrite_40}, 32'h0);
    preload = 1'b0;
    idle_inputs();
    @(posedge Clk_40); #1;
    Reset_n_40 = 1'b1;
    @(posedge Clk_40); #1;
    check("idle_outputs",
          LoadData_40 | Address_40 | WriteData_40 |
          {28'h0, Stall_40, AddrErr_40, MemRead_40, MemWrite_40}, 32'h0);

    // Word store then word load
    push(K_WR, 32'h10, 32'hDEADBEEF);
    issue(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 0);
    push(K_LD, 32'h10, 32'hDEADBEEF);
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0);

    // Byte store into lane 3, then signed/unsigned byte loads
    push(K_WR, 32'h14, 32'hAA223344);
    issue(1'b0, 1'b1, 2'b00, 1'b1, 32'h17, 32'h123456AA, 1);
    push(K_LD, 32'h14, 32'hFFFFFFAA);
    issue(1'b1, 1'b0, 2'b00, 1'b0, 32'h17, 32'h0, 0);
    push(K_LD, 32'h14, 32'h000000AA);
    issue(1'b1, 1'b0, 2'b00, 1'b1, 32'h17, 32'h0, 0);
    push(K_LD, 32'h14, 32'h00000033);
    issue(1'b1, 1'b0, 2'b00, 1'b0, 32'h15, 32'h0, 0);

    // Halfword store into upper lane, then halfword loads
    push(K_WR, 32'h18, 32'h80017788);
    issue(1'b0, 1'b1, 2'b01, 1'b0, 32'h1A, 32'hFFFF8001, 1);
    push(K_LD, 32'h18, 32'hFFFF8001);
    issue(1'b1, 1'b0, 2'b01, 1'b0, 32'h1A, 32'h0, 0);
    push(K_LD, 32'h18, 32'h00008001);
    issue(1'b1, 1'b0, 2'b01, 1'b1, 32'h1A, 32'h0, 0);
    push(K_LD, 32'h18, 32'h00007788);
    issue(1'b1, 1'b0, 2'b01, 1'b0, 32'h18, 32'h0, 0);

    // Rejected requests
    push(K_ERR, 32'h0, 32'h0);
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h12, 32'h0, 0);
    push(K_ERR, 32'h0, 32'h0);
    issue(1'b0, 1'b1, 2'b01, 1'b0, 32'h11, 32'h0000BBBB, 0);
    push(K_ERR, 32'h0, 32'h0);
    issue(1'b1, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 0);
    push(K_ERR, 32'h0, 32'h0);
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 0);
    push(K_ERR, 32'h0, 32'h0);
    issue(1'b1, 1'b1, 2'b10, 1'b0, 32'h10, 32'hCAFEF00D, 0);
    idle_inputs();
    @(posedge Clk_40); #1;
    check("mem_0x10_kept", mem[4], 32'hDEADBEEF);
    check("mem_0x14_kept", mem[5], 32'hAA223344);
    check("mem_0x18_kept", mem[6], 32'h80017788);

    // Reset asserted during COMMIT of sb 0x20
    MemWrite_in_40 = 1'b1; Size_40 = 2'b00; Address_in_40 = 32'h20;
    StoreData_40 = 32'h00000077;
    @(negedge Clk_40);
    check("rst_sb_stall", 32'(Stall_40), 32'h1);
    @(posedge Clk_40); #1;
    check("rst_commit_we", 32'(MemWrite_40), 32'h1);
    #2 Reset_n_40 = 1'b0;
    #1;
    check("rst_we_drop", 32'(MemWrite_40), 32'h0);
    idle_inputs();
    @(posedge Clk_40); #1;
    @(posedge Clk_40); #1;
    Reset_n_40 = 1'b1;
    @(posedge Clk_40); #1;
    check("rst_mem_0x20", mem[8], 32'h0);
    check("rst_idle_outputs",
          LoadData_40 | Address_40 | WriteData_40 |
          {28'h0, Stall_40, AddrErr_40, MemRead_40, MemWrite_40}, 32'h0);
    push(K_LD, 32'h20, 32'h0);
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 0);

    // Back-to-back sb 0x21 then lbu 0x21 right after COMMIT
    push(K_WR, 32'h20, 32'h00005A00);
    issue(1'b0, 1'b1, 2'b00, 1'b0, 32'h21, 32'h0000005A, 1);
    push(K_LD, 32'h20, 32'h0000005A);
    issue(1'b1, 1'b0, 2'b00, 1'b1, 32'h21, 32'h0, 0);
    idle_inputs();

    repeat (3) @(posedge Clk_40);
    #1;
    check("queue_empty", 32'(sb_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
